// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types, including the instruction-cache
// frame/state types and the default cache depth.
//   word_t          32-bit machine word
//   icache_tag_t    tag field sized for the smallest supported cache (2 sets)
//   icache_frame_t  one direct-mapped frame: valid, tag, data word
//   icache_state_t  IDLE / FETCH controller states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    // 2 sets leaves 32-3 = 29 tag bits; deeper caches zero-extend into this.
    localparam int ICACHE_TAGW = 29;

    typedef logic [ICACHE_TAGW-1:0] icache_tag_t;

    typedef struct packed {
        logic        valid;
        icache_tag_t tag;
        word_t       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache.
// Hits are answered combinationally; a miss moves to FETCH and reads the word
// from memory_control, writes the frame, then returns to IDLE so that the
// replayed request hits on the following cycle.
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   imemREN, imemaddr    datapath fetch request / byte address
//   flush                invalidate every frame (also aborts a fill)
//   ihit, imemload       instruction valid / instruction word to datapath
//   iREN, iaddr          fill read request / word-aligned address to memory
//   iwait, iload         memory stall (0 = iload valid) / fill data
module icache
    import cpu_types_pkg::*;
#(
    parameter int NSETS = ICACHE_SETS
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    input  logic  flush,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    localparam int IDX = $clog2(NSETS);

    icache_frame_t frames_q [NSETS];
    icache_state_t state_q;
    word_t         fill_q;
    logic          iren_q;
    word_t         iaddr_q;

    logic [IDX-1:0] req_idx, fill_idx;
    icache_tag_t    req_tag, fill_tag;
    logic           hit;

    assign req_idx  = imemaddr[IDX+1:2];
    assign req_tag  = icache_tag_t'(imemaddr >> (IDX + 2));
    assign fill_idx = fill_q[IDX+1:2];
    assign fill_tag = icache_tag_t'(fill_q >> (IDX + 2));

    // nRST gating keeps ihit low during the reset cycle itself, before the
    // valid bits have been cleared by the first reset edge.
    assign hit = nRST && (state_q == IDLE) && imemREN && !flush &&
                 frames_q[req_idx].valid && (frames_q[req_idx].tag == req_tag);

    assign ihit     = hit;
    assign imemload = hit ? frames_q[req_idx].data : '0;
    assign iREN     = iren_q;
    assign iaddr    = iaddr_q;

    // Tag/data fields are never reset; only valid bits carry meaning.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            fill_q  <= '0;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
            for (int i = 0; i < NSETS; i++) frames_q[i].valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        for (int i = 0; i < NSETS; i++) frames_q[i].valid <= 1'b0;
                    end else if (imemREN && !hit) begin
                        state_q <= FETCH;
                        fill_q  <= {imemaddr[31:2], 2'b00};
                        iren_q  <= 1'b1;
                        iaddr_q <= {imemaddr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    // flush wins over a completing fill: nothing is written.
                    if (flush) begin
                        for (int i = 0; i < NSETS; i++) frames_q[i].valid <= 1'b0;
                        state_q <= IDLE;
                        iren_q  <= 1'b0;
                        iaddr_q <= '0;
                    end else if (!iwait) begin
                        frames_q[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: iload};
                        state_q <= IDLE;
                        iren_q  <= 1'b0;
                        iaddr_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed stimulus for icache with a reference model that tracks,
// per set, which word address is resident, and a responder that plays
// memory_control with a programmable iwait latency.
module tb_icache;

    localparam int NSETS = 16;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int total = 0;
    int bad   = 0;

    icache #(.NSETS(NSETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .flush(flush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Backing memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_0005;
        return {16'hC0DE, a[15:0]};
    endfunction

    // memory_control stand-in: iwait held high for lat cycles of iREN.
    int lat = 2;
    int cnt = 0;
    always @(posedge CLK) cnt <= iREN ? cnt + 1 : 0;
    assign iwait = iREN && (cnt < lat);
    assign iload = mem_word(iaddr);

    // Reference model: resident word address per set.
    bit          m_ok   [NSETS];
    logic [31:0] m_addr [NSETS];
    bit          m_fetch = 1'b0;
    logic [31:0] m_fill  = '0;
    bit          run_cmp = 1'b0;

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % NSETS);
    endfunction

    function automatic bit model_hit();
        logic [31:0] al;
        al = imemaddr & ~32'h3;
        return nRST && !m_fetch && imemREN && !flush &&
               m_ok[slot(al)] && (m_addr[slot(al)] == al);
    endfunction

    always @(posedge CLK) begin
        if (!nRST) begin
            m_fetch <= 1'b0;
            m_fill  <= '0;
            foreach (m_ok[i]) m_ok[i] <= 1'b0;
        end else if (!m_fetch) begin
            if (flush) begin
                foreach (m_ok[i]) m_ok[i] <= 1'b0;
            end else if (imemREN && !model_hit()) begin
                m_fetch <= 1'b1;
                m_fill  <= imemaddr & ~32'h3;
            end
        end else begin
            if (flush) begin
                foreach (m_ok[i]) m_ok[i] <= 1'b0;
                m_fetch <= 1'b0;
            end else if (!iwait) begin
                m_ok[slot(m_fill)]   <= 1'b1;
                m_addr[slot(m_fill)] <= m_fill;
                m_fetch <= 1'b0;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (run_cmp) begin
            bit eh;
            eh = model_hit();
            cmp("m_ihit", {31'd0, ihit}, {31'd0, eh});
            cmp("m_imemload", imemload, eh ? mem_word(imemaddr & ~32'h3) : 32'h0);
            cmp("m_iREN", {31'd0, iREN}, {31'd0, m_fetch});
            cmp("m_iaddr", iaddr, m_fetch ? m_fill : 32'h0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Run cycles until the fill finishes; bounded.
    task automatic fill(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (iREN && n < 20);
        if (iREN) begin
            total++;
            bad++;
            $display("FAIL %s fill timeout actual=iREN stuck required=IDLE", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; lat = 2;
        repeat (3) step();
        run_cmp = 1'b1;
        #2;
        cmp("rst_ihit", {31'd0, ihit}, 32'd0);
        cmp("rst_iREN", {31'd0, iREN}, 32'd0);
        cmp("rst_iaddr", iaddr, 32'd0);
        cmp("rst_imemload", imemload, 32'd0);

        // Cold miss, two wait cycles.
        step(); nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; #2;
        cmp("cold_miss", {31'd0, ihit}, 32'd0);
        step(); #2;
        cmp("fetch_iREN", {31'd0, iREN}, 32'd1);
        cmp("fetch_iaddr", iaddr, 32'h40);
        step(); step(); #2;
        cmp("still_fetch", {31'd0, iREN}, 32'd1);
        step(); #2;
        cmp("cold_hit", {31'd0, ihit}, 32'd1);
        cmp("cold_data", imemload, 32'h2001_0005);
        step(); #2;
        cmp("rehit", {31'd0, ihit}, 32'd1);
        cmp("rehit_iREN", {31'd0, iREN}, 32'd0);

        // Conflict on set 0.
        step(); imemaddr = 32'h0; #2;
        cmp("miss0", {31'd0, ihit}, 32'd0);
        fill("fill0"); #2;
        cmp("hit0", {31'd0, ihit}, 32'd1);
        cmp("hit0_data", imemload, 32'hC0DE_0000);
        step(); imemaddr = 32'h40; #2;
        cmp("evict_miss40", {31'd0, ihit}, 32'd0);
        fill("fill40");
        step(); imemaddr = 32'h0; #2;
        cmp("evicted0", {31'd0, ihit}, 32'd0);
        fill("refill0");

        // Flush in IDLE.
        step(); imemaddr = 32'h4; #2;
        cmp("miss4", {31'd0, ihit}, 32'd0);
        fill("fill4"); #2;
        cmp("hit4", {31'd0, ihit}, 32'd1);
        step(); flush = 1'b1; #2;
        cmp("flush_gate", {31'd0, ihit}, 32'd0);
        step(); flush = 1'b0; #2;
        cmp("post_flush4", {31'd0, ihit}, 32'd0);
        fill("refill4");

        // Flush in FETCH with iwait=0 that cycle.
        lat = 0;
        step(); imemaddr = 32'h8; #2;
        cmp("miss8", {31'd0, ihit}, 32'd0);
        step(); flush = 1'b1; #2;
        cmp("abort_fetch", {31'd0, iREN}, 32'd1);
        step(); flush = 1'b0; #2;
        cmp("abort_idle", {31'd0, iREN}, 32'd0);
        cmp("abort_nowrite", {31'd0, ihit}, 32'd0);
        fill("fill8"); #2;
        cmp("hit8", {31'd0, ihit}, 32'd1);

        // Reset mid-fill.
        lat = 3;
        step(); imemaddr = 32'hC; #2;
        cmp("missC", {31'd0, ihit}, 32'd0);
        step(); nRST = 1'b0; #2;
        cmp("rstfill_fetch", {31'd0, iREN}, 32'd1);
        step(); nRST = 1'b1; imemaddr = 32'h8; #2;
        cmp("rstfill_iREN", {31'd0, iREN}, 32'd0);
        cmp("rstfill_lost8", {31'd0, ihit}, 32'd0);
        fill("refill8");

        // Abandoned fill still lands.
        lat = 2;
        step(); imemaddr = 32'h10; #2;
        cmp("miss10", {31'd0, ihit}, 32'd0);
        step(); imemREN = 1'b0; imemaddr = 32'h14;
        fill("fill10"); #2;
        cmp("abandon_noihit", {31'd0, ihit}, 32'd0);
        step(); imemREN = 1'b1; imemaddr = 32'h10; #2;
        cmp("abandon_hit", {31'd0, ihit}, 32'd1);
        cmp("abandon_data", imemload, 32'hC0DE_0010);

        // High tags, top set, ignored byte offset.
        step(); imemaddr = 32'hFFFF_FFFC; fill("fillFC"); #2;
        cmp("hitFC_data", imemload, 32'hC0DE_FFFC);
        step(); imemaddr = 32'h8000_0047; fill("fill47");
        step(); imemaddr = 32'h8000_0044; #2;
        cmp("offset_hit", {31'd0, ihit}, 32'd1);
        step(); imemaddr = 32'h0000_0044; #2;
        cmp("tag_miss44", {31'd0, ihit}, 32'd0);
        fill("fill44");

        step(); imemREN = 1'b0;
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The parameter list SHALL be: NSETS, 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 The port CLK SHALL be: input, 1, sole clock, all state updates on rising edge.
REQ-003 The port nRST SHALL be: input, 1, reset, synchronous and active-low.
REQ-004 The port imemREN SHALL be: input, 1, datapath instruction read request.
REQ-005 The port imemaddr SHALL be: input, 32 (word_t), datapath fetch byte address.
REQ-006 The port flush SHALL be: input, 1, invalidate all frames.
REQ-007 The port ihit SHALL be: output, 1, instruction valid this cycle.
REQ-008 The port imemload SHALL be: output, 32 (word_t), instruction to datapath.
REQ-009 The port iREN SHALL be: output, 1, read request to memory_control.
REQ-010 The port iaddr SHALL be: output, 32 (word_t), fill address to memory_control.
REQ-011 The port iwait SHALL be: input, 1, memory_control stall; 0 = iload valid.
REQ-012 The port iload SHALL be: input, 32 (word_t), fill data from memory_control.

Function
REQ-013 Address split SHALL be: index = imemaddr[IDX+1:2] with IDX = log2(NSETS); tag = imemaddr[31:IDX+2]; bits [1:0] ignored.
REQ-014 Each frame SHALL hold valid bit, tag, one data word.
REQ-015 Hit SHALL be combinational: state IDLE, imemREN=1, frame valid, tag equal -> ihit=1, imemload = frame data, same cycle.
REQ-016 ihit SHALL be 0 whenever imemREN=0, state is FETCH, or flush=1.
REQ-017 FSM states SHALL be IDLE and FETCH only.
REQ-018 IDLE->FETCH SHALL occur when imemREN=1, no hit, flush=0; the miss address is latched into a fill register that edge.
REQ-019 In FETCH, iREN SHALL be 1 and iaddr SHALL equal the latched fill address (word-aligned, [1:0]=00); in IDLE, iREN=0, iaddr=0.
REQ-020 FETCH with iwait=1 SHALL hold state and all frames.
REQ-021 FETCH with iwait=0 SHALL write frame[fill index] = {1, fill tag, iload} and return to IDLE; the next cycle a repeated request hits (miss penalty = RAM latency + 2 cycles).
REQ-022 A fill SHALL complete even if imemREN drops or imemaddr changes during FETCH; no ihit for the abandoned address.
REQ-023 A fill to an occupied index SHALL overwrite it (conflict eviction, no write-back).
REQ-024 flush=1 in IDLE SHALL clear every valid bit at that edge; tags/data need not clear.
REQ-025 flush=1 in FETCH SHALL abort the fill: clear all valid bits, no frame write, return to IDLE, even when iwait=0 that cycle.
REQ-026 The cache SHALL never assert any data-side signal; arbitration priority belongs to memory_control.

Reset
REQ-027 nRST=0 at a rising edge SHALL force state IDLE, all valid bits 0, fill register 0, regardless of state (including mid-FETCH).
REQ-028 During and after reset, ihit=0, imemload=0, iREN=0, iaddr=0 until a new request.

Structure
REQ-029 cpu_types_pkg SHALL gain icache_frame_t (valid, tag, word_t data), icache_state_t (IDLE, FETCH) and ICACHE_SETS default constant.
REQ-030 The design SHALL be one module; frame array inline, no sub-module.

Verification
REQ-031 Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, RAM returns 0x2001_0005 after 2 iwait cycles -> iREN=1, iaddr=0x40 during FETCH; ihit=1, imemload=0x2001_0005 one cycle after fill.
REQ-032 Hit: repeat 0x40 -> ihit=1 same cycle, iREN stays 0.
REQ-033 Conflict: NSETS=16, fetch 0x00 then 0x40 (same index 0) -> second misses, evicts; reread 0x00 misses again.
REQ-034 Flush: after filling 0x04, pulse flush one cycle -> next 0x04 request misses; flush mid-FETCH with iwait=0 -> no frame written.
REQ-035 Reset mid-fill: nRST=0 in FETCH -> next cycle iREN=0, prior hits now miss.
REQ-036 Abandon: drop imemREN in FETCH -> fill still written, ihit stays 0; later request to that address hits.
